// File: rtl/riscy_uart_rx.sv
// riscy_uart_rx: 8N1 UART receiver for the HPS UART0 TX line.
// Received bytes are buffered in a first-word-fall-through FIFO with valid/ready.
module riscy_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_busy,
  output logic                          rx_frame_err,
  output logic                          rx_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   C_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_sync1;
  logic          r_rxs;
  logic          r_ferr;
  logic          r_ovr;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_last;

  logic w_pop;
  logic w_full;
  logic w_stop_ok;
  logic w_push;

  assign rx_valid  = (r_count != '0);
  assign w_pop     = rx_valid & rx_ready;
  assign w_full    = (r_count == C_FULL);
  assign w_stop_ok = (r_state == S_STOP) && (r_cnt == C_LAST) && r_rxs;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push    = w_stop_ok && (!w_full || w_pop);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rxs) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rxs;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_ovr   <= !w_push;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BRK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BRK: begin
          r_cnt <= '0;
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty FIFO keeps presenting the last byte consumed
  assign rx_data      = rx_valid ? r_mem[r_rptr] : r_last;
  assign rx_count     = r_count;
  assign rx_busy      = (r_state != S_IDLE);
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;

endmodule
